call_button_conditioner: RTL

CALL_BUTTON_CONDITIONER -- requirements
Module: call_button_conditioner

---
 rtl/elevator_pkg.sv | 17 +
 rtl/button_debounce_cell.sv | 120 ++++++++++++
 rtl/call_button_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants and the per-button channel state encoding.
package elevator_pkg;

  localparam int NUM_FLOORS              = 10;
  localparam int FLOOR_WIDTH             = $clog2(NUM_FLOORS);
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int STUCK_CYCLES_DEFAULT    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_RELEASE_WAIT = 3'd3,
    ST_STUCK        = 3'd4
  } btn_state_t;

endpackage

// File: rtl/button_debounce_cell.sv
// One call-button channel: synchroniser, debounce/stuck FSM and registered outputs.
module button_debounce_cell
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       enable,
  output logic       request_pulse,
  output logic       stable,
  output logic       stuck,
  output logic       stuck_next,
  output logic [2:0] state_dbg
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > STUCK_CYCLES) ? DEBOUNCE_CYCLES : STUCK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] STUCK_LIMIT = CW'(STUCK_CYCLES);

  logic          sync_q1, sync_q2;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic          stable_d;

  assign count_inc = (count_q == '1) ? count_q : count_q + CW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_q2) begin
          state_d = ST_PRESS_WAIT;
          count_d = CW'(1);
        end else begin
          count_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_q2) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_inc >= DEB_LIMIT) begin
          state_d = ST_PRESSED;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      ST_PRESSED: begin
        if (!sync_q2) begin
          state_d = ST_RELEASE_WAIT;
          count_d = CW'(1);
        end else if (count_inc >= STUCK_LIMIT) begin
          state_d = ST_STUCK;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_q2) begin
          state_d = ST_PRESSED;
          count_d = '0;
        end else if (count_inc >= DEB_LIMIT) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      ST_STUCK: begin
        // Only a fully debounced release leaves STUCK; any 1 restarts the count.
        if (sync_q2) begin
          count_d = '0;
        end else if (count_inc >= DEB_LIMIT) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign stable_d   = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT) ||
                      (state_q == ST_STUCK);
  assign stuck_next = (state_q == ST_STUCK);
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      state_q       <= ST_IDLE;
      count_q       <= '0;
      stable        <= 1'b0;
      request_pulse <= 1'b0;
      stuck         <= 1'b0;
    end else begin
      sync_q1       <= button_raw;
      sync_q2       <= sync_q1;
      state_q       <= state_d;
      count_q       <= count_d;
      stable        <= stable_d;
      // stable still low while state is PRESSED means this is the entry from PRESS_WAIT.
      request_pulse <= enable && (state_q == ST_PRESSED) && !stable;
      stuck         <= stuck_next;
    end
  end

endmodule

// File: rtl/call_button_conditioner.sv
// Per-floor call-button conditioning: independent debounce channels plus a global stuck flag.
module call_button_conditioner #(
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = elevator_pkg::STUCK_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_FLOORS-1:0]   buttons_raw,
  input  logic                    enable,
  output logic [NUM_FLOORS-1:0]   new_requests,
  output logic [NUM_FLOORS-1:0]   buttons_stable,
  output logic [NUM_FLOORS-1:0]   stuck_flags,
  output logic                    any_stuck,
  output logic [3*NUM_FLOORS-1:0] channel_states
);

  logic [NUM_FLOORS-1:0] stuck_next;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_chan
    button_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_cell (
      .clk           (clk),
      .reset         (reset),
      .button_raw    (buttons_raw[f]),
      .enable        (enable),
      .request_pulse (new_requests[f]),
      .stable        (buttons_stable[f]),
      .stuck         (stuck_flags[f]),
      .stuck_next    (stuck_next[f]),
      .state_dbg     (channel_states[3*f +: 3])
    );
  end

  // Built from the next-state flags so it lands in the same cycle as stuck_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_stuck <= 1'b0;
    end else begin
      any_stuck <= |stuck_next;
    end
  end

endmodule
